// File: rtl/adc_emulator.sv
// Dual-channel ADC responder: CNVST/BUSY handshake and CS-gated MSB-first serial readout.
// Optional macro ADC_EMU_LFSR_EN replaces the sample ports with two on-chip LFSR sources.
`timescale 1ns/1ps
module adc_emulator #(
  parameter int unsigned DATA_BITS   = 14,
  parameter int unsigned CONV_DELAY  = 4,
  parameter int unsigned BUSY_CYCLES = 72
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CNVST_ADC,
  input  logic                 CS_ADC,
  input  logic                 SCLK_ADC,
  output logic                 BUSY_ADC,
  output logic                 DOUTA_ADC,
  output logic                 DOUTB_ADC,
  input  logic [DATA_BITS-1:0] data_a,
  input  logic [DATA_BITS-1:0] data_b,
  output logic [15:0]          conv_count,
  output logic                 overrun
);

  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONV} state_t;

  state_t               state_q;
  logic                 cnvst_q, cnvst_prev_q;
  logic                 cs_q, cs_prev_q;
  logic                 sclk_q, sclk_prev_q;
  logic [15:0]          cnt_q;
  logic [DATA_BITS-1:0] hold_a_q, hold_b_q;
  logic [DATA_BITS-1:0] sh_a_q, sh_b_q;
  logic [BCW-1:0]       bitcnt_q;
  logic                 busy_q;
  logic [15:0]          conv_count_q;
  logic                 overrun_q;

  logic                 cnvst_fall, cs_rise, sclk_fall;
  logic                 accept, busy_end, rd_en;
  logic [DATA_BITS-1:0] samp_a, samp_b;

  assign cnvst_fall = cnvst_prev_q & ~cnvst_q;
  assign cs_rise    = ~cs_prev_q & cs_q;
  assign sclk_fall  = sclk_prev_q & ~sclk_q;
  assign accept     = cnvst_fall && (state_q == S_IDLE);
  assign busy_end   = (state_q == S_CONV) && (cnt_q == '0);

`ifdef ADC_EMU_LFSR_EN
  logic [15:0] lfsr_a_q, lfsr_b_q;
  logic        unused_data;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_a_q <= 16'hACE1;
      lfsr_b_q <= 16'h1D2C;
    end else if (accept) begin
      lfsr_a_q <= lfsr_next(lfsr_a_q);
      lfsr_b_q <= lfsr_next(lfsr_b_q);
    end
  end

  assign samp_a      = lfsr_a_q[DATA_BITS-1:0];
  assign samp_b      = lfsr_b_q[DATA_BITS-1:0];
  assign unused_data = ^{data_a, data_b};
`else
  assign samp_a = data_a;
  assign samp_b = data_b;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnvst_q      <= 1'b1;
      cnvst_prev_q <= 1'b1;
      cs_q         <= 1'b1;
      cs_prev_q    <= 1'b1;
      sclk_q       <= 1'b1;
      sclk_prev_q  <= 1'b1;
      cnt_q        <= '0;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      bitcnt_q     <= '0;
      busy_q       <= 1'b0;
      conv_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      cnvst_q      <= CNVST_ADC;
      cnvst_prev_q <= cnvst_q;
      cs_q         <= CS_ADC;
      cs_prev_q    <= cs_q;
      sclk_q       <= SCLK_ADC;
      sclk_prev_q  <= sclk_q;

      case (state_q)
        S_IDLE: begin
          if (cnvst_fall) begin
            hold_a_q <= samp_a;
            hold_b_q <= samp_b;
            // A one-cycle delay skips WAIT so BUSY still rises exactly at t0+CONV_DELAY.
            if (CONV_DELAY == 1) begin
              busy_q  <= 1'b1;
              state_q <= S_CONV;
              cnt_q   <= 16'(BUSY_CYCLES - 1);
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 16'(CONV_DELAY - 2);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b1;
            state_q <= S_CONV;
            cnt_q   <= 16'(BUSY_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_CONV: begin
          if (cnt_q == '0) begin
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
            sh_a_q       <= hold_a_q;
            sh_b_q       <= hold_b_q;
            conv_count_q <= conv_count_q + 16'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (cnvst_fall && (state_q != S_IDLE))
        overrun_q <= 1'b1;

      // Load outranks both CS-rise abandon and a coincident SCLK shift.
      if (busy_end) begin
        bitcnt_q <= BCW'(DATA_BITS);
      end else if (cs_rise) begin
        bitcnt_q <= '0;
      end else if (sclk_fall && !cs_q && (bitcnt_q != '0)) begin
        sh_a_q   <= {sh_a_q[DATA_BITS-2:0], 1'b0};
        sh_b_q   <= {sh_b_q[DATA_BITS-2:0], 1'b0};
        bitcnt_q <= bitcnt_q - BCW'(1);
      end
    end
  end

  assign rd_en      = ~cs_q & (bitcnt_q != '0);
  assign DOUTA_ADC  = rd_en & sh_a_q[DATA_BITS-1];
  assign DOUTB_ADC  = rd_en & sh_b_q[DATA_BITS-1];
  assign BUSY_ADC   = busy_q;
  assign conv_count = conv_count_q;
  assign overrun    = overrun_q;

endmodule
